// File: rtl/hazard_control_if.sv
// ---------------------------------------------------------------------------
// hazard_control_if
//   Bundle of the hazard unit's pipeline-side signals.
//   master : pipeline side. Drives the register fields, RegWriteM, Stall and
//            CountClear. Receives the forwarding selects, StallCPU and the
//            performance counters.
//   slave  : the hazard unit itself.
// Parameters:
//   REG_ADDR_WIDTH : width of the register-address fields
//   COUNT_WIDTH    : width of each performance counter
// ---------------------------------------------------------------------------
interface hazard_control_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
);
  logic [REG_ADDR_WIDTH-1:0] RsE;
  logic [REG_ADDR_WIDTH-1:0] RtE;
  logic [REG_ADDR_WIDTH-1:0] WriteRegM;
  logic                      RegWriteM;
  logic                      Stall;
  logic                      CountClear;
  logic                      StallCPU;
  logic                      ForwardA_E;
  logic                      ForwardB_E;
  logic [COUNT_WIDTH-1:0]    FwdACount;
  logic [COUNT_WIDTH-1:0]    FwdBCount;
  logic [COUNT_WIDTH-1:0]    StallCount;

  modport master (
    output RsE, RtE, WriteRegM, RegWriteM, Stall, CountClear,
    input  StallCPU, ForwardA_E, ForwardB_E, FwdACount, FwdBCount, StallCount
  );

  modport slave (
    input  RsE, RtE, WriteRegM, RegWriteM, Stall, CountClear,
    output StallCPU, ForwardA_E, ForwardB_E, FwdACount, FwdBCount, StallCount
  );
endinterface

// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//   Hazard-resolution unit for the 3-stage pipeline. It compares the
//   Execute-stage source fields against the Memory-stage destination and
//   raises per-operand forwarding selects. It passes the external stall
//   request straight through to the CPU stall line.
//
//   Optional feature: define HAZARD_PERF_COUNTERS_EN to compile in the
//   saturating debug counters (forward-A, forward-B and stall cycles).
//   When the macro is undefined, the counters read 0, CountClear is ignored
//   and the unit contains no flops.
//
// Ports:
//   Clock    : system clock (used only by the counters)
//   Reset_n  : asynchronous active-low reset, clears the counters
//   bus      : hazard_control_if.slave
//              inputs  RsE, RtE, WriteRegM, RegWriteM, Stall, CountClear
//              outputs StallCPU, ForwardA_E, ForwardB_E,
//                      FwdACount, FwdBCount, StallCount
// ---------------------------------------------------------------------------
module hazard_control #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  hazard_control_if.slave  bus
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg   = '0;
  localparam logic [COUNT_WIDTH-1:0]    CountZero = '0;

  logic forwardA;
  logic forwardB;
  logic stallCpu;

  // Writes to $0 are discarded, so a match on $0 must never forward.
  assign forwardA = bus.RegWriteM && (bus.RsE == bus.WriteRegM) && (bus.RsE != ZeroReg);
  assign forwardB = bus.RegWriteM && (bus.RtE == bus.WriteRegM) && (bus.RtE != ZeroReg);

  // The M-stage result is always forwardable, so there is no load-use
  // interlock here. Stalls come only from the external request.
  assign stallCpu = bus.Stall;

  assign bus.ForwardA_E = forwardA;
  assign bus.ForwardB_E = forwardB;
  assign bus.StallCPU   = stallCpu;

`ifdef HAZARD_PERF_COUNTERS_EN

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] fwdACount;
  logic [COUNT_WIDTH-1:0] fwdBCount;
  logic [COUNT_WIDTH-1:0] stallCount;

  // Counters hold at all-ones instead of wrapping, so a long-running debug
  // session never shows a misleadingly small value.
  // NOTE: sequential state uses non-blocking assignments so every counter
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fwdACount  <= CountZero;
      fwdBCount  <= CountZero;
      stallCount <= CountZero;
    end else if (bus.CountClear) begin
      // Clear wins over a same-cycle increment.
      fwdACount  <= CountZero;
      fwdBCount  <= CountZero;
      stallCount <= CountZero;
    end else begin
      if (forwardA && (fwdACount != CountMax)) begin
        fwdACount <= fwdACount + CountOne;
      end
      if (forwardB && (fwdBCount != CountMax)) begin
        fwdBCount <= fwdBCount + CountOne;
      end
      if (stallCpu && (stallCount != CountMax)) begin
        stallCount <= stallCount + CountOne;
      end
    end
  end

  assign bus.FwdACount  = fwdACount;
  assign bus.FwdBCount  = fwdBCount;
  assign bus.StallCount = stallCount;

`else

  assign bus.FwdACount  = CountZero;
  assign bus.FwdBCount  = CountZero;
  assign bus.StallCount = CountZero;

  // Clock, Reset_n and CountClear stay on the port list for a uniform
  // interface but have no function in this build.
  logic unusedInputs;
  assign unusedInputs = &{1'b0, Clock, Reset_n, bus.CountClear};

`endif

endmodule

// File: tb/tb_hazard_control.sv
// ---------------------------------------------------------------------------
// tb_hazard_control
//   Scoreboard bench for hazard_control. Two instances share the same
//   stimulus: one with 32-bit counters and one with 4-bit counters, so that
//   saturation can be reached in a few cycles. The reference model counts
//   qualifying cycles since the last clear/reset and clips them to each
//   counter's maximum value.
// ---------------------------------------------------------------------------
module tb_hazard_control;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit CountersOn = 1'b1;
`else
  localparam bit CountersOn = 1'b0;
`endif

  localparam int unsigned WideMax   = 32'hFFFF_FFFF;
  localparam int unsigned NarrowMax = 15;

  logic Clock;
  logic Reset_n;

  hazard_control_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) busWide   ();
  hazard_control_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4))  busNarrow ();

  hazard_control #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) u_dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (busWide)
  );

  hazard_control #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) u_dutSat (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (busNarrow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        fwdA;
    logic        fwdB;
    logic        stall;
    int unsigned wA;
    int unsigned wB;
    int unsigned wS;
    int unsigned nA;
    int unsigned nB;
    int unsigned nS;
  } exp_t;

  exp_t expQ[$];

  int errors = 0;
  int checks = 0;

  // Qualifying cycles seen since the last clear or reset.
  int unsigned trueA = 0;
  int unsigned trueB = 0;
  int unsigned trueS = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic int unsigned expCount(input int unsigned cnt, input int unsigned maxVal);
    if (!CountersOn) return 0;
    return (cnt < maxVal) ? cnt : maxVal;
  endfunction

  task automatic setInputs(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                           input logic rw, input logic st, input logic clr);
    busWide.RsE        = rs;  busNarrow.RsE        = rs;
    busWide.RtE        = rt;  busNarrow.RtE        = rt;
    busWide.WriteRegM  = wr;  busNarrow.WriteRegM  = wr;
    busWide.RegWriteM  = rw;  busNarrow.RegWriteM  = rw;
    busWide.Stall      = st;  busNarrow.Stall      = st;
    busWide.CountClear = clr; busNarrow.CountClear = clr;
  endtask

  // One cycle of stimulus: drive just after the rising edge, queue the
  // expected response, then account for the edge that ends this cycle.
  task automatic driveCycle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                            input logic rw, input logic st, input logic clr);
    exp_t e;
    @(posedge Clock);
    #1;
    setInputs(rs, rt, wr, rw, st, clr);
    e.fwdA  = rw && (rs == wr) && (rs != 0);
    e.fwdB  = rw && (rt == wr) && (rt != 0);
    e.stall = st;
    e.wA = expCount(trueA, WideMax);
    e.wB = expCount(trueB, WideMax);
    e.wS = expCount(trueS, WideMax);
    e.nA = expCount(trueA, NarrowMax);
    e.nB = expCount(trueB, NarrowMax);
    e.nS = expCount(trueS, NarrowMax);
    expQ.push_back(e);
    if (clr) begin
      trueA = 0; trueB = 0; trueS = 0;
    end else begin
      if (e.fwdA)  trueA++;
      if (e.fwdB)  trueB++;
      if (e.stall) trueS++;
    end
  endtask

  task automatic checkCounters(input string tag, input int unsigned a, input int unsigned b,
                               input int unsigned s);
    check({tag, " wide FwdACount"},    busWide.FwdACount,    expCount(a, WideMax));
    check({tag, " wide FwdBCount"},    busWide.FwdBCount,    expCount(b, WideMax));
    check({tag, " wide StallCount"},   busWide.StallCount,   expCount(s, WideMax));
    check({tag, " narrow FwdACount"},  32'(busNarrow.FwdACount),  expCount(a, NarrowMax));
    check({tag, " narrow FwdBCount"},  32'(busNarrow.FwdBCount),  expCount(b, NarrowMax));
    check({tag, " narrow StallCount"}, 32'(busNarrow.StallCount), expCount(s, NarrowMax));
  endtask

  // Asynchronous reset in the middle of a cycle, released just after an edge.
  task automatic pulseReset();
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    setInputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    trueA = 0; trueB = 0; trueS = 0;
    #1;
    checkCounters("async reset", 0, 0, 0);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation on each
  // falling edge, well away from the edge that updates the counters.
  always @(negedge Clock) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("ForwardA_E", busWide.ForwardA_E, e.fwdA);
      check("ForwardB_E", busWide.ForwardB_E, e.fwdB);
      check("StallCPU",   busWide.StallCPU,   e.stall);
      check("wide FwdACount",    busWide.FwdACount,    e.wA);
      check("wide FwdBCount",    busWide.FwdBCount,    e.wB);
      check("wide StallCount",   busWide.StallCount,   e.wS);
      check("narrow FwdACount",  32'(busNarrow.FwdACount),  e.nA);
      check("narrow FwdBCount",  32'(busNarrow.FwdBCount),  e.nB);
      check("narrow StallCount", 32'(busNarrow.StallCount), e.nS);
    end
  end

  initial begin
    Reset_n = 1'b0;
    setInputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Control outputs follow their inputs while reset is held.
    #2;
    busWide.Stall = 1'b1;
    #1 check("StallCPU in reset (1)", busWide.StallCPU, 1'b1);
    busWide.Stall = 1'b0;
    #1 check("StallCPU in reset (0)", busWide.StallCPU, 1'b0);
    @(negedge Clock);
    #2;
    busWide.Stall = 1'b1;
    #1 check("StallCPU in reset (1 again)", busWide.StallCPU, 1'b1);
    setInputs(5'd17, 5'd17, 5'd17, 1'b1, 1'b0, 1'b0);
    #1;
    check("ForwardA_E in reset", busWide.ForwardA_E, 1'b1);
    check("ForwardB_E in reset", busWide.ForwardB_E, 1'b1);
    checkCounters("held reset", 0, 0, 0);

    setInputs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // Directed forwarding cases.
    driveCycle(5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0);
    driveCycle(5'd9,  5'd3,  5'd12, 1'b1, 1'b0, 1'b0);
    driveCycle(5'd9,  5'd3,  5'd4,  1'b1, 1'b0, 1'b0);
    driveCycle(5'd17, 5'd17, 5'd17, 1'b1, 1'b0, 1'b0);
    driveCycle(5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0);
    driveCycle(5'd4,  5'd8,  5'd8,  1'b1, 1'b1, 1'b0);

    // Ten stall cycles with operand A forwarded, then clear with stall high.
    pulseReset();
    for (int i = 0; i < 10; i++) driveCycle(5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0);
    driveCycle(5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1);
    #1 checkCounters("after 10 cycles", 10, 0, 10);
    driveCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 checkCounters("after clear", 0, 0, 0);

    // Twenty stall cycles: the 4-bit counter must stop at 15.
    for (int i = 0; i < 20; i++) driveCycle(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    driveCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 checkCounters("saturation", 0, 0, 20);

    // Randomized traffic with occasional clears and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulseReset();
      driveCycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
    end
    driveCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    @(negedge Clock);
    @(negedge Clock);
    check("scoreboard drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
